// File: rtl/pe_c_drain_pkg.sv
// ---------------------------------------------------------------------------
// pe_drain_pkg
// Shared constants and the FIFO entry type for the PE column drain.
//   IN_W        : width of the signed partial sum coming out of the PE
//   OUT_W       : width of the saturated signed result
//   SHIFT_W     : width of the rounding shift control
//   FIFO_DEPTH  : default number of buffered results (power of two)
//   SAT_MAX/MIN : clamp limits of the signed 8-bit result
//   drain_entry_t : one buffered result {first, data}
// ---------------------------------------------------------------------------
package pe_drain_pkg;

   localparam int IN_W       = 32'sd19;
   localparam int OUT_W      = 32'sd8;
   localparam int SHIFT_W    = 32'sd4;
   localparam int FIFO_DEPTH = 32'sd8;

   localparam int SAT_MAX = 32'sd127;
   localparam int SAT_MIN = -32'sd128;

   typedef struct packed {
      logic                    first;
      logic signed [OUT_W-1:0] data;
   } drain_entry_t;

endpackage : pe_drain_pkg

// File: rtl/pe_c_drain_if.sv
// ---------------------------------------------------------------------------
// pe_c_drain_if
// Ready/valid result stream from the drain to the writeback path.
//   out_data  : saturated, rounded result at the FIFO head
//   out_first : head entry is the first result of a new tile
//   out_valid : head entry present
//   out_ready : consumer takes the head when high together with out_valid
// master = drain side, slave = writeback side.
// ---------------------------------------------------------------------------
interface pe_c_drain_if;
   import pe_drain_pkg::*;

   logic signed [OUT_W-1:0] out_data;
   logic                    out_first;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output out_data,
      output out_first,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_first,
      input  out_valid,
      output out_ready
   );

endinterface : pe_c_drain_if

// File: rtl/pe_c_drain_fifo.sv
// ---------------------------------------------------------------------------
// pe_drain_fifo
// Synchronous FIFO with a registered head. A push is never stalled: when the
// FIFO is full and nothing leaves in the same cycle, the incoming entry is
// dropped and o_drop pulses for that cycle.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push/i_data: write request and entry
//   i_pop        : consumer takes the head (ignored while o_valid is low)
//   o_head/o_valid: registered head entry and its valid flag
//   o_full/o_empty: occupancy flags
//   o_drop       : the push of this cycle is being discarded
// ---------------------------------------------------------------------------
module pe_drain_fifo #(
   parameter int  DEPTH = pe_drain_pkg::FIFO_DEPTH,
   parameter type T     = pe_drain_pkg::drain_entry_t
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_head,
   output logic o_valid,
   output logic o_full,
   output logic o_empty,
   output logic o_drop
);
   import pe_drain_pkg::*;

   localparam int          AW      = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   T              r_head;
   logic          r_head_vld;

   logic          w_full;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_drop;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [AW:0]   w_remain;

   // Accept/drop decision and the read position after this edge
   always_comb begin
      w_full       = (r_count == L_DEPTH);
      w_pop        = i_pop && r_head_vld;
      // a pop in the same cycle frees the slot the push needs
      w_push_ok    = i_push && (!w_full || w_pop);
      w_drop       = i_push && w_full && !w_pop;
      w_rd_ptr_nxt = r_rd_ptr;
      if (w_pop) begin
         w_rd_ptr_nxt = r_rd_ptr + AW'(1'b1);
      end else begin
         w_rd_ptr_nxt = r_rd_ptr;
      end
      // entries already stored that remain after the pop; a push landing on
      // this edge only becomes visible at the head one edge later
      w_remain = r_count - (AW+1)'(w_pop);
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers, occupancy and the registered head
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= {AW{1'b0}};
         r_rd_ptr   <= {AW{1'b0}};
         r_count    <= {(AW+1){1'b0}};
         r_head     <= '0;
         r_head_vld <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1'b1);
         end
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_count    <= w_remain + (AW+1)'(w_push_ok);
         r_head_vld <= (w_remain != {(AW+1){1'b0}});
         if (w_remain != {(AW+1){1'b0}}) begin
            r_head <= r_mem[w_rd_ptr_nxt];
         end else begin
            r_head <= '0;
         end
      end
   end

   assign o_head  = r_head;
   assign o_valid = r_head_vld;
   assign o_full  = w_full;
   assign o_empty = (r_count == {(AW+1){1'b0}});
   assign o_drop  = w_drop;

endmodule : pe_drain_fifo

// File: rtl/pe_c_drain.sv
// ---------------------------------------------------------------------------
// pe_c_drain
// Collects one PE column's partial sums, rounds them with an arithmetic right
// shift (round half up), saturates to signed 8 bits and queues them for the
// writeback path. The mesh cannot be stalled, so a full queue drops the new
// result and raises a sticky overflow flag instead.
//   CLK, RST      : clock, asynchronous active-high reset
//   in_c          : signed partial sum from the PE
//   in_shift      : rounding shift amount (0..15)
//   in_propagate  : propagate bit; a change marks a tile boundary
//   in_valid      : qualifies in_c/in_shift/in_propagate
//   wb            : result stream (out_data/out_first/out_valid/out_ready)
//   overflow      : sticky, a result was dropped
//   sat_count     : saturated results seen, sticks at 0xFFFF
//   clr           : synchronous clear of overflow and sat_count
// Pipeline: capture (edge N) -> round/saturate (edge N+1) -> push (edge N+2)
// -> head visible after edge N+3.
// ---------------------------------------------------------------------------
module pe_c_drain #(
   parameter int IN_W    = pe_drain_pkg::IN_W,
   parameter int OUT_W   = pe_drain_pkg::OUT_W,
   parameter int SHIFT_W = pe_drain_pkg::SHIFT_W,
   parameter int DEPTH   = pe_drain_pkg::FIFO_DEPTH
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [IN_W-1:0]    in_c,
   input  logic [SHIFT_W-1:0] in_shift,
   input  logic               in_propagate,
   input  logic               in_valid,
   pe_c_drain_if.master       wb,
   output logic               overflow,
   output logic [15:0]        sat_count,
   input  logic               clr
);
   import pe_drain_pkg::*;

   localparam logic signed [IN_W:0] L_MAX = (IN_W+1)'(SAT_MAX);
   localparam logic signed [IN_W:0] L_MIN = (IN_W+1)'(SAT_MIN);

   // capture stage
   logic               r_s1_vld;
   logic [IN_W-1:0]    r_s1_c;
   logic [SHIFT_W-1:0] r_s1_shift;
   logic               r_s1_first;
   logic               r_last_prop;
   logic               r_last_prop_vld;

   // rounded/saturated stage, feeds the FIFO push
   logic               r_s2_vld;
   drain_entry_t       r_s2_entry;
   logic               r_s2_sat;

   logic               r_overflow;
   logic [15:0]        r_sat_count;

   logic signed [IN_W:0]    w_ext;
   logic signed [IN_W:0]    w_bias;
   logic signed [IN_W:0]    w_sum;
   logic signed [IN_W:0]    w_rnd;
   logic signed [OUT_W-1:0] w_sat_data;
   logic                    w_sat;

   drain_entry_t w_head;
   logic         w_head_vld;
   logic         w_full;
   logic         w_empty;
   logic         w_drop;
   logic         w_unused_flags;

   // Capture stage and tile-boundary tracking
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s1_vld        <= 1'b0;
         r_s1_c          <= {IN_W{1'b0}};
         r_s1_shift      <= {SHIFT_W{1'b0}};
         r_s1_first      <= 1'b0;
         r_last_prop     <= 1'b0;
         r_last_prop_vld <= 1'b0;
      end else begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s1_c     <= in_c;
            r_s1_shift <= in_shift;
            // nothing to compare against after reset, so that capture opens a tile
            r_s1_first      <= !r_last_prop_vld || (in_propagate != r_last_prop);
            r_last_prop     <= in_propagate;
            r_last_prop_vld <= 1'b1;
         end
      end
   end

   // Round half up with an arithmetic shift, then clamp to the output range
   always_comb begin
      w_ext      = {r_s1_c[IN_W-1], r_s1_c};
      w_bias     = {(IN_W+1){1'b0}};
      w_sum      = w_ext;
      w_rnd      = w_ext;
      w_sat_data = {OUT_W{1'b0}};
      w_sat      = 1'b0;
      if (r_s1_shift == {SHIFT_W{1'b0}}) begin
         w_rnd = w_ext;
      end else begin
         // one extra bit of headroom keeps the bias add from wrapping
         w_bias = {{IN_W{1'b0}}, 1'b1} << (r_s1_shift - {{(SHIFT_W-1){1'b0}}, 1'b1});
         w_sum  = w_ext + w_bias;
         w_rnd  = w_sum >>> r_s1_shift;
      end
      if (w_rnd > L_MAX) begin
         w_sat_data = OUT_W'(SAT_MAX);
         w_sat      = 1'b1;
      end else if (w_rnd < L_MIN) begin
         w_sat_data = OUT_W'(SAT_MIN);
         w_sat      = 1'b1;
      end else begin
         w_sat_data = w_rnd[OUT_W-1:0];
         w_sat      = 1'b0;
      end
   end

   // Register the finished result ahead of the FIFO push
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s2_vld   <= 1'b0;
         r_s2_entry <= '0;
         r_s2_sat   <= 1'b0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_entry.first <= r_s1_first;
            r_s2_entry.data  <= w_sat_data;
            r_s2_sat         <= w_sat;
         end
      end
   end

   pe_drain_fifo #(
      .DEPTH (DEPTH),
      .T     (drain_entry_t)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (r_s2_vld),
      .i_data  (r_s2_entry),
      .i_pop   (wb.out_ready),
      .o_head  (w_head),
      .o_valid (w_head_vld),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   // occupancy flags are available for integration but not needed here
   assign w_unused_flags = w_full ^ w_empty;

   // Sticky loss flag and saturation counter; clr takes priority over events
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_overflow  <= 1'b0;
         r_sat_count <= 16'h0000;
      end else if (clr) begin
         r_overflow  <= 1'b0;
         r_sat_count <= 16'h0000;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (r_s2_vld && r_s2_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'h0001;
         end
      end
   end

   assign wb.out_data  = w_head.data;
   assign wb.out_first = w_head.first;
   assign wb.out_valid = w_head_vld;
   assign overflow     = r_overflow;
   assign sat_count    = r_sat_count;

endmodule : pe_c_drain

// File: doc/pe_c_drain.md
# pe_c_drain

Downstream collector for one PE column's partial-sum output in the 8x16 bit-serial mesh. It captures the 19-bit `c` result whenever the PE flags it valid, applies a rounding arithmetic right shift and saturates to signed 8-bit. It buffers the results in a small FIFO and presents them on a ready/valid stream to the writeback path. The PE has no backpressure, so the block absorbs bursts and reports loss instead of stalling the mesh.

## Interface
Parameters:
- `IN_W`, 19: width of incoming partial sum `c` (signed).
- `OUT_W`, 8: width of saturated output (signed).
- `SHIFT_W`, 4: width of shift control.
- `DEPTH`, 8: FIFO entries (power of two).

Ports:
- `CLK`  in  1: single clock, all state on rising edge.
- `RST`  in  1: reset, asynchronous and active-high; clears all state.
- `in_c`  in  IN_W: partial sum from the PE `io_out_c1`.
- `in_shift`  in  SHIFT_W: shift amount from the PE `io_out_control_shift1`.
- `in_propagate`  in  1: propagate bit from the PE `io_out_control_propagate1`.
- `in_valid`  in  1: qualifies `in_c`, `in_shift` and `in_propagate` in that cycle.
- `out_data`  out  OUT_W: saturated, rounded result at the FIFO head.
- `out_first`  out  1: head entry is the first result after a propagate toggle (tile boundary).
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts the head when high with `out_valid`.
- `overflow`  out  1: sticky; a result was dropped on a full FIFO.
- `sat_count`  out  16: number of saturated results; sticks at 0xFFFF.
- `clr`  in  1: synchronous clear of `overflow` and `sat_count`.

## Operation
- **S1 (capture):** on `in_valid`, register `c`, `shift`, `propagate` and valid. The first flag is set when `propagate` differs from the last captured propagate. The first capture after reset always sets first.
- **S2 (round):**
  - Sign-extend `c` to IN_W+1 bits.
  - If shift = 0, pass the value unchanged.
  - Otherwise compute `(c + (1 << (shift-1))) >>> shift`, arithmetic shift, round-half-up toward +inf.
  - Shift values 0..15 are all legal.
- **S3 (saturate/push):**
  - Clamp to [-128, 127]. A clamp increments `sat_count` unless it already holds 0xFFFF.
  - Push {first, data} into the FIFO.
- **FIFO:**
  - Pop occurs when `out_valid && out_ready`.
  - If a push arrives when full and there is no pop in the same cycle, drop the incoming entry, leave the stored entries untouched, and set `overflow`.
  - Push and pop in the same cycle while full are both honoured; no drop occurs.
  - Push and pop in the same cycle while empty: the entry is written, and it is popped on a later cycle only.
- **`clr`:** clears `overflow` and `sat_count`. If a saturation or drop occurs in the same cycle, `clr` wins and the event is lost.
- **Reset:** at any time, discards pipeline and FIFO contents. Outputs go to `out_data`=0, `out_first`=0, `out_valid`=0, `overflow`=0, `sat_count`=0. The last-propagate tracker is invalidated.

## Timing
- Pipeline latency: `in_valid` at edge N gives the FIFO push at edge N+2. On an empty FIFO, `out_valid`=1 is visible after edge N+3.
- Throughput: one result per cycle in, one per cycle out.
- `out_data` and `out_first` are registered FIFO-head outputs. They are stable while `out_valid && !out_ready`.
- `overflow` rises the cycle after the dropped push edge.
- `sat_count` updates at the push edge.
- No combinational path from `out_ready` to `out_valid` or from `in_*` to any output.

## Structure
- Package `pe_drain_pkg`:
  - Width constants IN_W/OUT_W/SHIFT_W.
  - SAT_MAX = 127 and SAT_MIN = -128.
  - Entry typedef {logic first; logic signed [OUT_W-1:0] data}.
- Sub-module `pe_drain_fifo`: parameterised synchronous FIFO (DEPTH, entry type) with registered head, full/empty flags, and an overflow-pulse output.
- Round/saturate logic stays inline in `pe_c_drain`.

## Test plan
- **Rounding:** c=256, shift=2 -> `out_data`=0x40. c=-5 (0x7FFFB), shift=1 -> 0xFE. c=6, shift=2 -> 0x02. Each has `out_valid` 3 cycles after input.
- **Saturation:** c=1000, shift=0 -> 0x7F and `sat_count`=1. c=-1000, shift=0 -> 0x80 and `sat_count`=2. Then `clr` -> 0.
- **Backpressure/overflow:** hold `out_ready`=0 and send 9 valid values 1..9 at shift 0. Require `overflow`=1 one cycle after the 9th push. Draining yields exactly 1..8 in order.
- **Full with simultaneous pop:** FIFO full, `out_ready`=1 and a new push in the same cycle -> no overflow, count stays 8, order preserved.
- **Tile boundary:** `in_propagate` sequence 0,0,1,1,0 -> `out_first` sequence 1,0,1,0,1.
- **Reset mid-operation:** assert `RST` with 5 entries queued and 2 in the pipeline -> all outputs 0 immediately. After release, no stale entry appears. The next input has `out_first`=1.
